// File: rtl/clk_div_freq_checker.sv
// -----------------------------------------------------------------------------
// clk_div_freq_checker
//
// Self-check for a 50%-duty N.5 clock divider output. The divided clock
// (clk_in) is synchronised into the clk domain, and its rising edges are
// counted over a fixed window of WIN_CYCLES clk cycles. The count is reported
// together with a pass/fail verdict against EXP_EDGES +/- TOL.
//
// Optional feature macro: CLK_CHK_STICKY_ERR_EN
//   defined     : err_sticky latches any failing verdict until rst
//   not defined : err_sticky is tied low and no register is built
//
// Ports
//   clk         in   sampling clock (source clock of the divider)
//   rst         in   asynchronous active-low reset
//   clk_in      in   divided clock under test, asynchronous to clk
//   start       in   request one measurement, sampled only in IDLE
//   busy        out  high while arming and measuring
//   done        out  one-cycle pulse when a result is published
//   pass        out  verdict of the last completed measurement
//   edge_count  out  edge count of the last completed measurement
//   err_sticky  out  sticky failure flag (see macro above)
// -----------------------------------------------------------------------------
module clk_div_freq_checker #(
  parameter int unsigned WIN_CYCLES = 70,
  parameter int unsigned EXP_EDGES  = 20,
  parameter int unsigned TOL        = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] edge_count,
  output logic             err_sticky
);

  localparam int unsigned WW = (WIN_CYCLES > 2) ? $clog2(WIN_CYCLES) : 1;
  localparam logic [WW-1:0] WIN_LAST = WW'(WIN_CYCLES - 1);
  localparam logic [WW-1:0] ARM_LAST = WW'(1);
  localparam logic signed [CNT_W:0] EXP_S = (CNT_W + 1)'(EXP_EDGES);
  localparam logic signed [CNT_W:0] TOL_S = (CNT_W + 1)'(TOL);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    MEASURE,
    EVAL,
    REPORT
  } state_t;

  state_t           state;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic [WW-1:0]    win_cnt;
  logic [CNT_W-1:0] edge_cnt;

  logic             sat;
  logic signed [CNT_W:0] diff;
  logic signed [CNT_W:0] mag;
  logic             pass_eval;

`ifdef CLK_CHK_STICKY_ERR_EN
  logic             err_q;
  assign err_sticky = err_q;
`else
  assign err_sticky = 1'b0;
`endif

  // s1/s2 resynchronise clk_in; s3 delays s2 so a rising edge gives one pulse.
  assign rise = s2 & ~s3;

  // Verdict logic. A saturated counter no longer reflects the real edge count,
  // so it always fails regardless of the arithmetic.
  always_comb begin
    sat       = &edge_cnt;
    diff      = $signed({1'b0, edge_cnt}) - EXP_S;
    mag       = diff[CNT_W] ? -diff : diff;
    pass_eval = !sat && (mag <= TOL_S);
  end

  // EVAL gives the final MEASURE-cycle increment time to settle in edge_cnt,
  // so the result registers load one cycle later and done lines up with REPORT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      edge_count <= '0;
`ifdef CLK_CHK_STICKY_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      s1   <= clk_in;
      s2   <= s1;
      s3   <= s2;
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state    <= ARM;
            busy     <= 1'b1;
            win_cnt  <= '0;
            edge_cnt <= '0;
          end
        end

        // Two cycles for the synchroniser to flush stale clk_in history.
        ARM: begin
          if (win_cnt == ARM_LAST) begin
            state   <= MEASURE;
            win_cnt <= '0;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end

        MEASURE: begin
          if (rise && !sat) begin
            edge_cnt <= edge_cnt + 1'b1;
          end
          if (win_cnt == WIN_LAST) begin
            state   <= EVAL;
            win_cnt <= '0;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end

        EVAL: begin
          state      <= REPORT;
          busy       <= 1'b0;
          done       <= 1'b1;
          edge_count <= edge_cnt;
          pass       <= pass_eval;
`ifdef CLK_CHK_STICKY_ERR_EN
          if (!pass_eval) begin
            err_q <= 1'b1;
          end
`endif
        end

        REPORT: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_freq_checker.sv
`timescale 1ns/100ps
module tb_clk_div_freq_checker;

  localparam int WIN = 70;
  localparam int EXP = 20;
  localparam int TOL = 1;

`ifdef CLK_CHK_STICKY_ERR_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  // clk_in waveform modes
  localparam int M_LOW    = 0;
  localparam int M_HIGH   = 1;
  localparam int M_DIV35  = 2;
  localparam int M_DIV4   = 3;
  localparam int M_TOGGLE = 4;
  localparam int M_RAND   = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_in = 1'b0;
  logic       start;
  logic       busy, done, pass, err_sticky;
  logic [7:0] edge_count;
  logic       busy4, done4, pass4, err4;
  logic [3:0] edge_count4;

  int checks = 0;
  int failures = 0;
  int mode = M_LOW;
  int cyc = 0;
  int done_cnt = 0;
  bit hist [0:65535];
  bit sticky_m = 1'b0;

  clk_div_freq_checker #(.WIN_CYCLES(WIN), .EXP_EDGES(EXP), .TOL(TOL), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .clk_in(clk_in), .start(start), .busy(busy), .done(done),
    .pass(pass), .edge_count(edge_count), .err_sticky(err_sticky)
  );

  clk_div_freq_checker #(.WIN_CYCLES(WIN), .EXP_EDGES(EXP), .TOL(TOL), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .clk_in(clk_in), .start(start), .busy(busy4), .done(done4),
    .pass(pass4), .edge_count(edge_count4), .err_sticky(err4)
  );

  always #5 clk = ~clk;

  // hist[k] = clk_in as seen at posedge number k
  always @(posedge clk) begin
    hist[cyc] <= clk_in;
    cyc       <= cyc + 1;
    done_cnt  <= done_cnt + int'(done);
  end

  // clk_in generator; transitions land at 2 ns after a negedge plus multiples of
  // the half period, never on a posedge.
  always begin : gen
    int m;
    m = mode;
    @(negedge clk);
    #2;
    while (mode == m) begin
      case (m)
        M_LOW:    begin clk_in = 1'b0; #10; end
        M_HIGH:   begin clk_in = 1'b1; #10; end
        M_DIV35:  begin clk_in = ~clk_in; #17.5; end
        M_DIV4:   begin clk_in = ~clk_in; #20; end
        M_TOGGLE: begin clk_in = ~clk_in; #10; end
        default:  begin clk_in = 1'($urandom_range(0, 1)); #10; end
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: rising edges of clk_in among the WIN+1 samples taken from the
  // start-sampling edge onward, clipped to the counter range.
  function automatic int model_count(input int s0, input int cnt_w);
    int n = 0;
    int maxv = (1 << cnt_w) - 1;
    for (int m = 0; m < WIN; m++) begin
      if (!hist[s0 + m] && hist[s0 + m + 1]) n++;
    end
    return (n > maxv) ? maxv : n;
  endfunction

  function automatic bit model_pass(input int c, input int cnt_w);
    return (c != (1 << cnt_w) - 1) && (c >= EXP - TOL) && (c <= EXP + TOL);
  endfunction

  // One measurement; s0 = posedge index sampling start, lat = done edge - s0.
  task automatic measure(input bit extra_start, output int s0, output int lat);
    @(negedge clk);
    start = 1'b1;
    s0 = cyc;
    @(negedge clk);
    start = 1'b0;
    if (extra_start) begin
      repeat (12) @(negedge clk);
      check("busy_in_measure", 32'(busy), 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        lat = (cyc - 1) - s0;
        break;
      end
    end
    if (lat < 0) begin
      failures++;
      checks++;
      $display("FAIL done_timeout: got none expected done within 200 cycles");
    end
  endtask

  task automatic check_result(input string tag, input int s0, input int lat);
    int  c;
    bit  p;
    c = model_count(s0, 8);
    p = model_pass(c, 8);
    if (!p) sticky_m = STICKY_EN;
    check({tag, "_latency"}, 32'(lat), WIN + 3);
    check({tag, "_count"}, 32'(edge_count), 32'(c));
    check({tag, "_pass"}, 32'(pass), 32'(p));
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_sticky"}, 32'(err_sticky), 32'(sticky_m));
  endtask

  typedef struct {
    int    mode;
    int    lo;
    int    hi;
    bit    exp_pass;
    string name;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int s0, lat, dc, t1, s1;

    vecs[0] = '{M_DIV35,  19, 21, 1'b1, "div35"};
    vecs[1] = '{M_DIV4,   17, 18, 1'b0, "div4"};
    vecs[2] = '{M_LOW,     0,  0, 1'b0, "low"};
    vecs[3] = '{M_HIGH,    0,  0, 1'b0, "high"};
    vecs[4] = '{M_TOGGLE, 35, 35, 1'b0, "toggle"};

    rst = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_count", 32'(edge_count), 0);
    check("rst_sticky", 32'(err_sticky), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // table-driven waveforms
    for (int v = 0; v < 5; v++) begin
      mode = vecs[v].mode;
      repeat (10) @(negedge clk);
      measure(1'b0, s0, lat);
      check_result(vecs[v].name, s0, lat);
      check({vecs[v].name, "_range"},
            32'((int'(edge_count) >= vecs[v].lo) && (int'(edge_count) <= vecs[v].hi)), 1);
      check({vecs[v].name, "_verdict"}, 32'(pass), 32'(vecs[v].exp_pass));
      if (vecs[v].mode == M_TOGGLE) begin
        check("sat4_count", 32'(edge_count4), 32'(model_count(s0, 4)));
        check("sat4_count_max", 32'(edge_count4), 15);
        check("sat4_pass", 32'(pass4), 0);
      end
    end

    // randomized clk_in
    mode = M_RAND;
    repeat (5) @(negedge clk);
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(1, 8)) @(negedge clk);
      measure(1'b0, s0, lat);
      check_result("rand", s0, lat);
    end

    // second start during MEASURE is ignored
    mode = M_DIV35;
    repeat (10) @(negedge clk);
    dc = done_cnt;
    measure(1'b1, s0, lat);
    check_result("restart", s0, lat);
    repeat (100) @(negedge clk);
    check("restart_one_done", 32'(done_cnt - dc), 1);
    check("restart_idle", 32'(busy), 0);

    // start held high: back-to-back runs, one IDLE cycle between them
    @(negedge clk);
    start = 1'b1;
    s0 = cyc;
    t1 = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin t1 = cyc - 1; break; end
    end
    check("b2b_first", 32'(t1 - s0), WIN + 3);
    s1 = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin s1 = cyc - 1; break; end
    end
    start = 1'b0;
    check("b2b_spacing", 32'(s1 - t1), WIN + 5);
    check("b2b_count", 32'(edge_count), 32'(model_count(t1 + 2, 8)));
    repeat (100) @(negedge clk);

    // reset 30 cycles into MEASURE aborts without done
    dc = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (31) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_pass", 32'(pass), 0);
    check("abort_count", 32'(edge_count), 0);
    check("abort_sticky", 32'(err_sticky), 0);
    sticky_m = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - dc), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    measure(1'b0, s0, lat);
    check_result("after_rst", s0, lat);
    check("after_rst_verdict", 32'(pass), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
